parking_gate_scheduler: RTL and testbench

Sequences the single shared barrier of the parking lot between an entry lane and an exit lane. Arbitrates requests round-robin and holds the barrier open for exactly one vehicle. Enforces a pass-through timeout and a guard interval before the next grant. Maintains lot occupancy and gates entry grants on full/blocked conditions; sits above the PIN gate controller, consuming its Bloqueo indication.

---
 rtl/parking_pkg.sv | 19 +
 rtl/parking_gate_scheduler_gate_timer.sv | 29 ++
 rtl/parking_gate_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_parking_gate_scheduler.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types for the parking lot barrier sequencing logic.
// State encoding, lane identifiers and the PIN constant shared with the gate controller.
package parking_pkg;

    // One-hot, matching the gate controller's encoding style
    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_OPEN  = 3'b010,
        ST_CLOSE = 3'b100
    } state_e;

    typedef enum logic {
        LANE_ENTRY = 1'b0,
        LANE_EXIT  = 1'b1
    } lane_e;

    localparam logic [15:0] PIN_CORRECTO = 16'h2468;

endpackage

// File: rtl/parking_gate_scheduler_gate_timer.sv
// Loadable down-counter used for both the open window and the guard interval.
// Ports: Clk, Reset, Load_i, Value_i, En_i (decrement), Zero_o (count == 0).
module gate_timer #(
    parameter int TMR_W = 7
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load_i,
    input  logic [TMR_W-1:0] Value_i,
    input  logic             En_i,
    output logic             Zero_o
);

    logic [TMR_W-1:0] cnt_q;

    // Load has priority; the count parks at zero
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (Load_i) begin
            cnt_q <= Value_i;
        end else if (En_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - TMR_W'(1);
        end
    end

    assign Zero_o = (cnt_q == '0);

endmodule

// File: rtl/parking_gate_scheduler.sv
// Shared barrier sequencer: round-robin entry/exit grants, open window with
// timeout, guard interval, and lot occupancy tracking.
// Ports: Clk, Reset (sync, active-high); ReqEntrada/ReqSalida lane requests;
// Termino pass sensor pulse; Bloqueo gate lock; GntEntrada/GntSalida grant
// pulses; AbrirPuerta barrier command; Ocupacion/Lleno/Vacio occupancy;
// Timeout open-window expiry pulse.
// Optional PARKING_STATS_EN: adds TotalEntradas, TotalSalidas, TimeoutCnt.
module parking_gate_scheduler
    import parking_pkg::*;
#(
    parameter int CAPACITY     = 16,
    parameter int OCC_W        = 5,
    parameter int OPEN_CYCLES  = 64,
    parameter int GUARD_CYCLES = 4,
    parameter int TMR_W        = 7
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ReqEntrada,
    input  logic             ReqSalida,
    input  logic             Termino,
    input  logic             Bloqueo,
    output logic             GntEntrada,
    output logic             GntSalida,
    output logic             AbrirPuerta,
    output logic [OCC_W-1:0] Ocupacion,
    output logic             Lleno,
    output logic             Vacio,
`ifdef PARKING_STATS_EN
    output logic [15:0]      TotalEntradas,
    output logic [15:0]      TotalSalidas,
    output logic [7:0]       TimeoutCnt,
`endif
    output logic             Timeout
);

    localparam logic [OCC_W-1:0] OCC_MAX   = OCC_W'(CAPACITY);
    localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] GRD_LOAD  = TMR_W'(GUARD_CYCLES - 1);

    state_e           state_q, state_d;
    lane_e            lane_q, lane_d;
    lane_e            last_q, last_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             gnt_e_q, gnt_e_d;
    logic             gnt_s_q, gnt_s_d;
    logic             abrir_q, abrir_d;
    logic             tmo_q, tmo_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_en;
    logic             tmr_zero;

    logic             full;
    logic             empty;
    logic             elig_e;
    logic             elig_s;

    assign full   = (occ_q == OCC_MAX);
    assign empty  = (occ_q == '0);
    assign elig_e = ReqEntrada & ~full & ~Bloqueo;
    assign elig_s = ReqSalida & ~empty;

    gate_timer #(
        .TMR_W (TMR_W)
    ) u_timer (
        .Clk     (Clk),
        .Reset   (Reset),
        .Load_i  (tmr_load),
        .Value_i (tmr_val),
        .En_i    (tmr_en),
        .Zero_o  (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        last_d   = last_q;
        occ_d    = occ_q;
        gnt_e_d  = 1'b0;
        gnt_s_d  = 1'b0;
        abrir_d  = 1'b0;
        tmo_d    = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = GRD_LOAD;
        tmr_en   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (elig_e || elig_s) begin
                    // Contention goes to the lane not served last
                    if (elig_e && (!elig_s || last_q == LANE_EXIT)) begin
                        lane_d  = LANE_ENTRY;
                        last_d  = LANE_ENTRY;
                        gnt_e_d = 1'b1;
                    end else begin
                        lane_d  = LANE_EXIT;
                        last_d  = LANE_EXIT;
                        gnt_s_d = 1'b1;
                    end
                    abrir_d  = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = OPEN_LOAD;
                    state_d  = ST_OPEN;
                end
            end

            ST_OPEN: begin
                abrir_d = 1'b1;
                if (lane_q == LANE_ENTRY && Bloqueo) begin
                    // Lock during an entry pass aborts it uncounted
                    abrir_d  = 1'b0;
                    tmr_load = 1'b1;
                    state_d  = ST_CLOSE;
                end else if (Termino) begin
                    if (lane_q == LANE_ENTRY) begin
                        if (occ_q != OCC_MAX) occ_d = occ_q + OCC_W'(1);
                    end else begin
                        if (occ_q != '0) occ_d = occ_q - OCC_W'(1);
                    end
                    abrir_d  = 1'b0;
                    tmr_load = 1'b1;
                    state_d  = ST_CLOSE;
                end else if (tmr_zero) begin
                    tmo_d    = 1'b1;
                    abrir_d  = 1'b0;
                    tmr_load = 1'b1;
                    state_d  = ST_CLOSE;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            ST_CLOSE: begin
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            lane_q  <= LANE_ENTRY;
            last_q  <= LANE_EXIT;
            occ_q   <= '0;
            gnt_e_q <= 1'b0;
            gnt_s_q <= 1'b0;
            abrir_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            last_q  <= last_d;
            occ_q   <= occ_d;
            gnt_e_q <= gnt_e_d;
            gnt_s_q <= gnt_s_d;
            abrir_q <= abrir_d;
            tmo_q   <= tmo_d;
        end
    end

    assign GntEntrada  = gnt_e_q;
    assign GntSalida   = gnt_s_q;
    assign AbrirPuerta = abrir_q;
    assign Ocupacion   = occ_q;
    assign Lleno       = full;
    assign Vacio       = empty;
    assign Timeout     = tmo_q;

`ifdef PARKING_STATS_EN
    logic [15:0] tot_e_q;
    logic [15:0] tot_s_q;
    logic [7:0]  tmo_cnt_q;
    logic        pass_e;
    logic        pass_s;

    // Completed passes mirror the counted branch of the OPEN state
    assign pass_e = (state_q == ST_OPEN) && (lane_q == LANE_ENTRY)
                  && !Bloqueo && Termino;
    assign pass_s = (state_q == ST_OPEN) && (lane_q == LANE_EXIT)
                  && Termino;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            tot_e_q   <= '0;
            tot_s_q   <= '0;
            tmo_cnt_q <= '0;
        end else begin
            if (pass_e) tot_e_q <= tot_e_q + 16'd1;
            if (pass_s) tot_s_q <= tot_s_q + 16'd1;
            if (tmo_d && tmo_cnt_q != 8'hFF) tmo_cnt_q <= tmo_cnt_q + 8'd1;
        end
    end

    assign TotalEntradas = tot_e_q;
    assign TotalSalidas  = tot_s_q;
    assign TimeoutCnt    = tmo_cnt_q;
`endif

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Directed testbench for parking_gate_scheduler.
// Drives inputs and samples outputs on the falling clock edge.
module tb_parking_gate_scheduler;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       ReqEntrada;
    logic       ReqSalida;
    logic       Termino;
    logic       Bloqueo;
    logic       GntEntrada;
    logic       GntSalida;
    logic       AbrirPuerta;
    logic [4:0] Ocupacion;
    logic       Lleno;
    logic       Vacio;
    logic       Timeout;
`ifdef PARKING_STATS_EN
    logic [15:0] TotalEntradas;
    logic [15:0] TotalSalidas;
    logic [7:0]  TimeoutCnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    parking_gate_scheduler dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .ReqEntrada  (ReqEntrada),
        .ReqSalida   (ReqSalida),
        .Termino     (Termino),
        .Bloqueo     (Bloqueo),
        .GntEntrada  (GntEntrada),
        .GntSalida   (GntSalida),
        .AbrirPuerta (AbrirPuerta),
        .Ocupacion   (Ocupacion),
        .Lleno       (Lleno),
        .Vacio       (Vacio),
`ifdef PARKING_STATS_EN
        .TotalEntradas (TotalEntradas),
        .TotalSalidas  (TotalSalidas),
        .TimeoutCnt    (TimeoutCnt),
`endif
        .Timeout     (Timeout)
    );

    // Waits (bounded) for a grant on the requested lane; no checking here
    task automatic wait_grant(input bit entry, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge Clk);
            if (entry ? GntEntrada : GntSalida) ok = 1'b1;
        end
    endtask

    // One complete counted pass; returns after the guard interval
    task automatic do_pass(input bit entry, output bit ok);
        if (entry) ReqEntrada = 1'b1;
        else       ReqSalida  = 1'b1;
        wait_grant(entry, 40, ok);
        ReqEntrada = 1'b0;
        ReqSalida  = 1'b0;
        Termino    = ok;
        @(negedge Clk);
        Termino = 1'b0;
        repeat (5) @(negedge Clk);
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        ReqEntrada = 1'b0;
        ReqSalida  = 1'b0;
        Termino    = 1'b0;
        Bloqueo    = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if ({GntEntrada, GntSalida, AbrirPuerta, Lleno, Vacio, Timeout} !== 6'b000010
            || Ocupacion !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b%b abrir=%b lleno=%b vacio=%b tmo=%b occ=%0d, want 00 0 0 1 0 occ=0",
                     GntEntrada, GntSalida, AbrirPuerta, Lleno, Vacio, Timeout, Ocupacion);
        end
    endtask

    task automatic test_single_entry;
        bit ok;
        int open_cnt;
        int gnt_cnt;
        int closed_bad;
        ReqEntrada = 1'b1;
        wait_grant(1'b1, 10, ok);
        ReqEntrada = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL entry_grant: got no GntEntrada, want one");
        end
        open_cnt = AbrirPuerta ? 1 : 0;
        gnt_cnt  = GntEntrada ? 1 : 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge Clk);
            if (AbrirPuerta) open_cnt++;
            if (GntEntrada) gnt_cnt++;
            if (i == 10) Termino = 1'b1;
        end
        @(negedge Clk);
        Termino = 1'b0;
        checks++;
        if (open_cnt !== 11 || AbrirPuerta !== 1'b0) begin
            errors++;
            $display("FAIL entry_open_len: got %0d cycles (now %b), want 11 (now 0)",
                     open_cnt, AbrirPuerta);
        end
        checks++;
        if (gnt_cnt !== 1) begin
            errors++;
            $display("FAIL entry_gnt_pulses: got %0d, want 1", gnt_cnt);
        end
        checks++;
        if (Ocupacion !== 5'd1 || Vacio !== 1'b0) begin
            errors++;
            $display("FAIL entry_count: got occ=%0d vacio=%b, want occ=1 vacio=0",
                     Ocupacion, Vacio);
        end
        closed_bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (AbrirPuerta || GntEntrada || GntSalida) closed_bad++;
            @(negedge Clk);
        end
        checks++;
        if (closed_bad !== 0) begin
            errors++;
            $display("FAIL guard_closed: got %0d open/grant cycles, want 0", closed_bad);
        end
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_round_robin;
        bit ok;
        bit seq_ok;
        bit [2:0] seen;
        repeat (5) do_pass(1'b1, ok);
        do_pass(1'b0, ok);
        checks++;
        if (Ocupacion !== 5'd5) begin
            errors++;
            $display("FAIL rr_setup: got occ=%0d, want 5", Ocupacion);
        end
        ReqEntrada = 1'b1;
        ReqSalida  = 1'b1;
        seen = 3'b000;
        seq_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ok = 1'b0;
            for (int i = 0; i < 30 && !ok; i++) begin
                @(negedge Clk);
                if (GntEntrada || GntSalida) ok = 1'b1;
            end
            if (!ok) seq_ok = 1'b0;
            seen[k] = GntSalida;
            if (GntEntrada && GntSalida) seq_ok = 1'b0;
            Termino = 1'b1;
            @(negedge Clk);
            Termino = 1'b0;
        end
        ReqEntrada = 1'b0;
        ReqSalida  = 1'b0;
        repeat (6) @(negedge Clk);
        checks++;
        if (!seq_ok || seen !== 3'b010) begin
            errors++;
            $display("FAIL rr_order: got salida-flags(k2..k0)=%b ok=%b, want 010 ok=1",
                     seen, seq_ok);
        end
        checks++;
        if (Ocupacion !== 5'd6) begin
            errors++;
            $display("FAIL rr_count: got occ=%0d, want 6", Ocupacion);
        end
    endtask

    task automatic test_full;
        bit ok;
        int bad;
        repeat (10) do_pass(1'b1, ok);
        checks++;
        if (Ocupacion !== 5'd16 || Lleno !== 1'b1) begin
            errors++;
            $display("FAIL full_flag: got occ=%0d lleno=%b, want 16 1", Ocupacion, Lleno);
        end
        ReqEntrada = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge Clk);
            if (GntEntrada || AbrirPuerta) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL full_no_entry: got %0d grant/open cycles, want 0", bad);
        end
        ReqSalida = 1'b1;
        wait_grant(1'b0, 10, ok);
        ReqSalida = 1'b0;
        Termino = ok;
        @(negedge Clk);
        Termino = 1'b0;
        checks++;
        if (!ok || Ocupacion !== 5'd15) begin
            errors++;
            $display("FAIL full_exit: got grant=%b occ=%0d, want 1 15", ok, Ocupacion);
        end
        wait_grant(1'b1, 20, ok);
        ReqEntrada = 1'b0;
        Termino = ok;
        @(negedge Clk);
        Termino = 1'b0;
        checks++;
        if (!ok || Ocupacion !== 5'd16) begin
            errors++;
            $display("FAIL full_reentry: got grant=%b occ=%0d, want 1 16", ok, Ocupacion);
        end
        repeat (5) @(negedge Clk);
        do_pass(1'b0, ok);
    endtask

    task automatic test_timeout;
        bit ok;
        int n;
        int early_closed;
        ReqEntrada = 1'b1;
        wait_grant(1'b1, 10, ok);
        ReqEntrada = 1'b0;
        n = 0;
        early_closed = 0;
        while (!Timeout && n < 100) begin
            @(negedge Clk);
            n++;
            if (n < 64 && !AbrirPuerta) early_closed++;
        end
        checks++;
        if (!ok || n !== 64) begin
            errors++;
            $display("FAIL timeout_delay: got %0d cycles (grant=%b), want 64", n, ok);
        end
        checks++;
        if (early_closed !== 0 || AbrirPuerta !== 1'b0 || Ocupacion !== 5'd15) begin
            errors++;
            $display("FAIL timeout_state: got early_closed=%0d abrir=%b occ=%0d, want 0 0 15",
                     early_closed, AbrirPuerta, Ocupacion);
        end
        @(negedge Clk);
        checks++;
        if (Timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: got Timeout=%b after one cycle, want 0", Timeout);
        end
        repeat (5) @(negedge Clk);
    endtask

    task automatic test_termino_at_zero;
        bit ok;
        int tmo_seen;
        ReqEntrada = 1'b1;
        wait_grant(1'b1, 10, ok);
        ReqEntrada = 1'b0;
        tmo_seen = 0;
        repeat (63) begin
            @(negedge Clk);
            if (Timeout) tmo_seen++;
        end
        Termino = 1'b1;
        @(negedge Clk);
        Termino = 1'b0;
        if (Timeout) tmo_seen++;
        @(negedge Clk);
        if (Timeout) tmo_seen++;
        checks++;
        if (!ok || tmo_seen !== 0 || Ocupacion !== 5'd16) begin
            errors++;
            $display("FAIL termino_at_zero: got grant=%b tmo=%0d occ=%0d, want 1 0 16",
                     ok, tmo_seen, Ocupacion);
        end
        repeat (5) @(negedge Clk);
        do_pass(1'b0, ok);
    endtask

    task automatic test_bloqueo;
        bit ok;
        int bad;
        ReqEntrada = 1'b1;
        wait_grant(1'b1, 10, ok);
        repeat (2) @(negedge Clk);
        Bloqueo = 1'b1;
        @(negedge Clk);
        checks++;
        if (!ok || AbrirPuerta !== 1'b0 || Timeout !== 1'b0 || Ocupacion !== 5'd15) begin
            errors++;
            $display("FAIL bloqueo_abort: got grant=%b abrir=%b tmo=%b occ=%0d, want 1 0 0 15",
                     ok, AbrirPuerta, Timeout, Ocupacion);
        end
        bad = 0;
        repeat (15) begin
            @(negedge Clk);
            if (GntEntrada || AbrirPuerta) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bloqueo_inhibit: got %0d grant/open cycles, want 0", bad);
        end
        ReqEntrada = 1'b0;
        Bloqueo = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_reset_mid_open;
        bit ok;
        ReqEntrada = 1'b1;
        wait_grant(1'b1, 10, ok);
        ReqEntrada = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        checks++;
        if (!ok || AbrirPuerta !== 1'b0 || Ocupacion !== 5'd0 || Vacio !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_open: got grant=%b abrir=%b occ=%0d vacio=%b, want 1 0 0 1",
                     ok, AbrirPuerta, Ocupacion, Vacio);
        end
    endtask

    task automatic test_exit_empty;
        int bad;
        ReqSalida = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            Termino = (i % 7 == 3);
            @(negedge Clk);
            if (GntSalida || AbrirPuerta) bad++;
        end
        ReqSalida = 1'b0;
        Termino = 1'b0;
        checks++;
        if (bad !== 0 || Ocupacion !== 5'd0 || Vacio !== 1'b1) begin
            errors++;
            $display("FAIL exit_when_empty: got bad=%0d occ=%0d vacio=%b, want 0 0 1",
                     bad, Ocupacion, Vacio);
        end
    endtask

    initial begin
        test_reset;
        test_single_entry;
        test_round_robin;
        test_full;
        test_timeout;
        test_termino_at_zero;
        test_bloqueo;
        test_reset_mid_open;
        test_exit_empty;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
